// File: rtl/fb_port_arbiter_pkg.sv
// Shared definitions for the frame buffer port arbiter.
//   - Frame buffer geometry (320x240 words of RGB444).
//   - Default address/data widths and the draw starvation limit.
//   - RAM slot owner encoding used by the arbiter's response mux.
package fb_port_arbiter_pkg;

    // Word address width of the frame buffer (shared with the display path).
    localparam int DISP_ADDR_WIDTH  = 17;
    localparam int PIX_W            = 12;
    localparam int FB_DEPTH_WORDS   = 76800;
    localparam int STARVE_LIMIT_DEF = 8;

    // Who used the RAM slot in a given cycle; registered so the following
    // cycle knows where the synchronous RAM read data belongs.
    typedef enum logic [2:0] {
        OWN_NONE       = 3'd0,
        OWN_DISP_RAM   = 3'd1,
        OWN_DISP_CACHE = 3'd2,
        OWN_DRAW_RD    = 3'd3,
        OWN_DRAW_WR    = 3'd4
    } owner_e;

endpackage

// File: rtl/fb_disp_cache.sv
// One-entry display read cache (tag + data register).
// Ports:
//   clk, reset         clock, asynchronous active-high reset (invalidates)
//   inv                synchronous invalidate
//   lookup_addr        display address to compare; hit is combinational
//   rd_data            cached pixel (0 when the entry is invalid)
//   alloc/alloc_addr   claim the entry for a RAM read issued this cycle
//   fill_data          RAM read data, consumed the cycle after alloc
//   wr_en/wr_addr/wr_data  write-through update from a granted draw write
module fb_disp_cache
    import fb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DISP_ADDR_WIDTH,
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inv,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] rd_data,
    input  logic              alloc,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic              valid_q, valid_d;
    logic              fill_pend_q, fill_pend_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] cur_data;

    always_comb begin
        // The tag is claimed at the issue edge so a back-to-back duplicate
        // read hits; until the fill lands the data comes straight off the RAM.
        cur_data = fill_pend_q ? fill_data : data_q;
        hit      = valid_q && (lookup_addr == tag_q);
        rd_data  = valid_q ? cur_data : '0;

        valid_d     = valid_q;
        fill_pend_d = 1'b0;
        tag_d       = tag_q;
        data_d      = cur_data;

        // A draw write is newer than any in-flight fill of the same word.
        if (wr_en && valid_q && (wr_addr == tag_q)) begin
            data_d = wr_data;
        end
        if (alloc) begin
            valid_d     = 1'b1;
            tag_d       = alloc_addr;
            fill_pend_d = 1'b1;
        end
        if (inv) begin
            valid_d     = 1'b0;
            fill_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            fill_pend_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            fill_pend_q <= fill_pend_d;
        end
    end

    // Tag and data are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame buffer port arbiter: shares the single-port frame buffer RAM between
// the display read path (hard real-time) and a draw master (req/gnt).
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   disp_req, disp_addr            display pixel request
//   disp_rdata, disp_underrun      display response (1 cycle later), stale flag
//   drw_req/we/addr/wdata          draw request, held until drw_gnt
//   drw_gnt                        combinational grant
//   drw_rvalid, drw_rdata          draw read response (1 cycle after grant)
//   ram_addr/we/wdata, ram_rdata   synchronous single-port RAM interface
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DISP_ADDR_WIDTH,
    parameter int DATA_W       = PIX_W,
    parameter int FB_DEPTH     = FB_DEPTH_WORDS,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_underrun,
    input  logic              drw_req,
    input  logic              drw_we,
    input  logic [ADDR_W-1:0] drw_addr,
    input  logic [DATA_W-1:0] drw_wdata,
    output logic              drw_gnt,
    output logic              drw_rvalid,
    output logic [DATA_W-1:0] drw_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] FB_END  = ADDR_W'(FB_DEPTH);

    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] disp_hold_q, disp_hold_d;
    logic [DATA_W-1:0] drw_hold_q, drw_hold_d;
    logic              underrun_q, underrun_d;
    logic              drw_rvalid_q, drw_rvalid_d;

    logic              cache_hit;
    logic [DATA_W-1:0] cache_rd_data;
    logic              drw_in_range;
    logic              starve;
    logic              drw_gnt_c;
    logic              disp_from_cache;

    // Slot decision for the current cycle.
    always_comb begin
        drw_in_range    = (drw_addr < FB_END);
        starve          = drw_req && (starve_cnt_q >= CNT_MAX);
        owner_d         = OWN_NONE;
        drw_gnt_c       = 1'b0;
        disp_from_cache = 1'b0;
        underrun_d      = 1'b0;

        if (!reset) begin
            if (disp_req) begin
                if (cache_hit) begin
                    disp_from_cache = 1'b1;
                    drw_gnt_c       = drw_req;
                end else if (starve) begin
                    // Draw has waited long enough: display gets whatever the
                    // cache holds and the miss is flagged as an underrun.
                    disp_from_cache = 1'b1;
                    underrun_d      = 1'b1;
                    drw_gnt_c       = 1'b1;
                end else begin
                    owner_d = OWN_DISP_RAM;
                end
            end else begin
                drw_gnt_c = drw_req;
            end

            // Out-of-range draw accesses are granted but never touch the RAM.
            if (drw_gnt_c && drw_in_range) begin
                owner_d = drw_we ? OWN_DRAW_WR : OWN_DRAW_RD;
            end else if (disp_from_cache) begin
                owner_d = OWN_DISP_CACHE;
            end
        end
    end

    // Response capture and starve counter.
    always_comb begin
        drw_rvalid_d = drw_gnt_c && !drw_we;

        drw_hold_d = (owner_q == OWN_DRAW_RD) ? ram_rdata : drw_hold_q;
        if (drw_gnt_c && !drw_we && !drw_in_range) begin
            drw_hold_d = '0;
        end

        disp_hold_d = (owner_q == OWN_DISP_RAM) ? ram_rdata : disp_hold_q;
        if (disp_from_cache) begin
            // Sampled before this edge's write-through, so a same-cycle
            // draw write to the cached word is not visible yet.
            disp_hold_d = cache_rd_data;
        end

        if (!drw_req || drw_gnt_c) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
            disp_hold_q  <= '0;
            drw_hold_q   <= '0;
            underrun_q   <= 1'b0;
            drw_rvalid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            disp_hold_q  <= disp_hold_d;
            drw_hold_q   <= drw_hold_d;
            underrun_q   <= underrun_d;
            drw_rvalid_q <= drw_rvalid_d;
        end
    end

    fb_disp_cache #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cache (
        .clk         (clk),
        .reset       (reset),
        .inv         (1'b0),
        .lookup_addr (disp_addr),
        .hit         (cache_hit),
        .rd_data     (cache_rd_data),
        .alloc       (owner_d == OWN_DISP_RAM),
        .alloc_addr  (disp_addr),
        .fill_data   (ram_rdata),
        .wr_en       (owner_d == OWN_DRAW_WR),
        .wr_addr     (drw_addr),
        .wr_data     (drw_wdata)
    );

    // RAM data for last cycle's read is routed straight through so both
    // response paths keep a single cycle of latency.
    always_comb begin
        disp_rdata    = (owner_q == OWN_DISP_RAM) ? ram_rdata : disp_hold_q;
        drw_rdata     = (owner_q == OWN_DRAW_RD) ? ram_rdata : drw_hold_q;
        disp_underrun = underrun_q;
        drw_rvalid    = drw_rvalid_q;
        drw_gnt       = drw_gnt_c;

        ram_addr = '0;
        if (owner_d == OWN_DISP_RAM) begin
            ram_addr = disp_addr;
        end else if ((owner_d == OWN_DRAW_RD) || (owner_d == OWN_DRAW_WR)) begin
            ram_addr = drw_addr;
        end
        ram_we    = (owner_d == OWN_DRAW_WR);
        ram_wdata = ram_we ? drw_wdata : '0;
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter with a synchronous RAM model.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        disp_req = 1'b0;
    logic [16:0] disp_addr = '0;
    logic [11:0] disp_rdata;
    logic        disp_underrun;
    logic        drw_req = 1'b0;
    logic        drw_we = 1'b0;
    logic [16:0] drw_addr = '0;
    logic [11:0] drw_wdata = '0;
    logic        drw_gnt;
    logic        drw_rvalid;
    logic [11:0] drw_rdata;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [11:0] data;
        logic        urun;
    } exp_t;

    exp_t dq[$];
    exp_t wq[$];

    fb_port_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .disp_req      (disp_req),
        .disp_addr     (disp_addr),
        .disp_rdata    (disp_rdata),
        .disp_underrun (disp_underrun),
        .drw_req       (drw_req),
        .drw_we        (drw_we),
        .drw_addr      (drw_addr),
        .drw_wdata     (drw_wdata),
        .drw_gnt       (drw_gnt),
        .drw_rvalid    (drw_rvalid),
        .drw_rdata     (drw_rdata),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Power-up contents of the frame buffer.
    function automatic logic [11:0] init_val(input logic [16:0] a);
        logic [16:0] t;
        case (a)
            17'd5:   return 12'hABC;
            17'd6:   return 12'h123;
            17'd7:   return 12'h111;
            default: begin
                t = a * 17'd7 + 17'd3;
                return t[11:0];
            end
        endcase
    endfunction

    logic [11:0] mem [0:131071];
    bit          written [0:131071];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic dr, input logic [16:0] da, input logic wr,
                         input logic we, input logic [16:0] wa, input logic [11:0] wd);
        @(posedge clk);
        #1;
        disp_req  = dr;
        disp_addr = da;
        drw_req   = wr;
        drw_we    = we;
        drw_addr  = wa;
        drw_wdata = wd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic push_disp(input logic [11:0] d, input logic u);
        exp_t e;
        e.cyc = cyc + 1; e.data = d; e.urun = u;
        dq.push_back(e);
    endtask

    task automatic push_drw(input logic [11:0] d);
        exp_t e;
        e.cyc = cyc + 1; e.data = d; e.urun = 1'b0;
        wq.push_back(e);
    endtask

    // Response monitor: pops scoreboard entries when they fall due.
    always @(negedge clk) begin
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
            chk("disp_rdata", 32'(disp_rdata), 32'(dq[0].data));
            chk("disp_underrun", 32'(disp_underrun), 32'(dq[0].urun));
            void'(dq.pop_front());
        end else begin
            chk("disp_underrun_idle", 32'(disp_underrun), 32'd0);
        end
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            chk("drw_rvalid", 32'(drw_rvalid), 32'd1);
            chk("drw_rdata", 32'(drw_rdata), 32'(wq[0].data));
            void'(wq.pop_front());
        end else begin
            chk("drw_rvalid_idle", 32'(drw_rvalid), 32'd0);
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_disp_rdata", 32'(disp_rdata), 32'd0);
        chk("rst_drw_rdata", 32'(drw_rdata), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_drw_gnt", 32'(drw_gnt), 32'd0);
        reset = 1'b0;
        idle();
        chk("idle_disp_rdata", 32'(disp_rdata), 32'd0);
        chk("idle_ram_wdata", 32'(ram_wdata), 32'd0);

        // First display access misses; draw read waits one cycle
        drive(1'b1, 17'd0, 1'b1, 1'b0, 17'd200, '0);
        chk("t1_ram_addr", 32'(ram_addr), 32'd0);
        chk("t1_gnt_miss", 32'(drw_gnt), 32'd0);
        push_disp(init_val(17'd0), 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 17'd200, '0);
        chk("t1_gnt_idle", 32'(drw_gnt), 32'd1);
        chk("t1_ram_addr_drw", 32'(ram_addr), 32'd200);
        push_drw(init_val(17'd200));
        idle();

        // Duplicate reads free slots for the draw master
        drive(1'b1, 17'd5, 1'b1, 1'b1, 17'd100, 12'hFFF);
        chk("t2_gnt_a", 32'(drw_gnt), 32'd0);
        push_disp(12'hABC, 1'b0);
        drive(1'b1, 17'd5, 1'b1, 1'b1, 17'd100, 12'hFFF);
        chk("t2_gnt_b", 32'(drw_gnt), 32'd1);
        chk("t2_ram_we_b", 32'(ram_we), 32'd1);
        push_disp(12'hABC, 1'b0);
        drive(1'b1, 17'd6, 1'b1, 1'b1, 17'd100, 12'hFFF);
        chk("t2_gnt_c", 32'(drw_gnt), 32'd0);
        push_disp(12'h123, 1'b0);
        drive(1'b1, 17'd6, 1'b1, 1'b1, 17'd100, 12'hFFF);
        chk("t2_gnt_d", 32'(drw_gnt), 32'd1);
        push_disp(12'h123, 1'b0);
        idle();
        drive(1'b0, '0, 1'b1, 1'b0, 17'd100, '0);
        chk("t2_rd100_gnt", 32'(drw_gnt), 32'd1);
        push_drw(12'hFFF);
        idle();

        // Starvation: draw preempts the 9th consecutive display miss
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 17'(300 + i), 1'b1, 1'b0, 17'd400, '0);
            if (i < 8) begin
                chk("t3_gnt_wait", 32'(drw_gnt), 32'd0);
                push_disp(init_val(17'(300 + i)), 1'b0);
            end else begin
                chk("t3_gnt_starve", 32'(drw_gnt), 32'd1);
                push_disp(init_val(17'd307), 1'b1);
                push_drw(init_val(17'd400));
            end
        end
        drive(1'b1, 17'd309, 1'b0, 1'b0, '0, '0);
        chk("t3_after_miss_ram", 32'(ram_addr), 32'd309);
        push_disp(init_val(17'd309), 1'b0);
        idle();

        // Write coherence on the cached word
        drive(1'b1, 17'd7, 1'b0, 1'b0, '0, '0);
        push_disp(12'h111, 1'b0);
        drive(1'b1, 17'd7, 1'b1, 1'b1, 17'd7, 12'h222);
        chk("t4_gnt", 32'(drw_gnt), 32'd1);
        push_disp(12'h111, 1'b0);
        drive(1'b1, 17'd7, 1'b0, 1'b0, '0, '0);
        push_disp(12'h222, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 17'd7, '0);
        push_drw(12'h222);
        idle();

        // Out-of-range draw accesses and the last valid word
        drive(1'b0, '0, 1'b1, 1'b0, 17'd76800, '0);
        chk("t5_gnt_rd_oor", 32'(drw_gnt), 32'd1);
        chk("t5_we_rd_oor", 32'(ram_we), 32'd0);
        push_drw(12'h000);
        drive(1'b0, '0, 1'b1, 1'b1, 17'd80000, 12'h555);
        chk("t5_gnt_wr_oor", 32'(drw_gnt), 32'd1);
        chk("t5_we_wr_oor", 32'(ram_we), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0, 17'd76799, '0);
        chk("t5_gnt_last", 32'(drw_gnt), 32'd1);
        push_drw(init_val(17'd76799));
        idle();

        // Reset right after a draw read grant
        drive(1'b0, '0, 1'b1, 1'b0, 17'd10, '0);
        chk("t6_gnt", 32'(drw_gnt), 32'd1);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        drw_req = 1'b0;
        #1;
        chk("t6_rst_ram_we", 32'(ram_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 17'd5, 1'b1, 1'b1, 17'd50, 12'h777);
        chk("t6_miss_after_rst", 32'(drw_gnt), 32'd0);
        chk("t6_ram_addr", 32'(ram_addr), 32'd5);
        push_disp(12'hABC, 1'b0);
        idle();
        repeat (3) idle();

        chk("disp_queue_drained", 32'(dq.size()), 32'd0);
        chk("drw_queue_drained", 32'(wq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
